keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//   Input counterpart of the 7-seg mux: scans a 4x4 hex keypad matrix by driving one column
//   low at a time and reading the active-low rows. Debounces over whole scans and produces a
//   4-bit key code with a strobe and a pending/ack handshake. Sits beside mux7seg on board clk
//   and lets the operator enter nibbles (program/data entry, TEST override) into the CPU top.
// PARAMETERS
//   SCAN_DIV        12000  clk cycles per column step (1 ms @ 12 MHz); must be >= 4
//   DEBOUNCE_SCANS  5      consecutive identical full scans needed to accept press/release; >= 1
// PORTS
//   clk         in   1  board clock; the only clock in the block
//   rstN        in   1  asynchronous, active-low reset
//   rowIn       in   4  keypad rows, active-low (pulled up), asynchronous to clk
//   colOut      out  4  column drive, active-low, exactly one bit low at all times
//   keyCode     out  4  last accepted key = {rowIdx[1:0], colIdx[1:0]}; held until next accept
//   keyStrobe   out  1  one-cycle pulse when a press is accepted
//   keyDown     out  1  level: debounced key currently held
//   keyPending  out  1  accepted key not yet acknowledged
//   keyAck      in   1  consumer ack; clears keyPending and keyOverrun
//   keyOverrun  out  1  sticky: a press was accepted while keyPending was already 1
// BEHAVIOUR
//   Reset (async): colOut=4'b1110, colIdx=0, divCnt=0, row synchronisers=4'b1111, keyCode=0,
//     keyStrobe=0, keyDown=0, keyPending=0, keyOverrun=0, FSM=IDLE, stableCnt=0, scan accumulators cleared.
//     Reset mid-scan or mid-debounce discards all partial state; no strobe is emitted.
//   rowIn goes through a 2-FF synchroniser (reset value 1). Every sample uses the synchronised value.
//   divCnt counts 0..SCAN_DIV-1 and wraps. When divCnt==SCAN_DIV-1:
//     - sample the synchronised rows for the current column;
//     - advance colIdx (3 wraps to 0) and set colOut=~(1<<colIdx_next).
//   Per-scan result, taken at the col-3 sample (scanDone, 1 cycle):
//     NONE if no row bit is low in any column; SINGLE(code) if exactly one bit is low across
//     all 4 columns; MULTI if more than one. The accumulators are cleared for the next scan.
//   FSM, evaluated only on scanDone; stableCnt is 3 bits wide and saturating:
//     IDLE:    SINGLE(c) -> cand=c, stableCnt=1; go to PRESSED if DEBOUNCE_SCANS==1, else DEB_PRESS.
//              NONE or MULTI -> stay.
//     DEB_PRESS: SINGLE(cand) -> stableCnt++; on reaching DEBOUNCE_SCANS go to PRESSED.
//              Any other result (NONE, MULTI, or a different code) -> IDLE.
//     PRESSED: NONE -> stableCnt=1, then DEB_REL (go straight to IDLE if DEBOUNCE_SCANS==1).
//              SINGLE (any code) or MULTI -> stay. There is no rollover; all keys must be released.
//     DEB_REL: NONE -> stableCnt++; on reaching DEBOUNCE_SCANS go to IDLE.
//              Any press -> PRESSED.
//   On entry to PRESSED: registered outputs in the cycle after scanDone: keyCode=cand,
//     keyStrobe=1 for 1 cycle, keyDown=1. keyDown falls in the cycle after the scanDone that enters IDLE.
//   Handshake: keyStrobe sets keyPending. keyAck clears keyPending and keyOverrun.
//     If keyStrobe and keyAck occur in the same cycle, the set wins (keyPending=1, keyOverrun=0).
//     keyStrobe while keyPending==1 sets keyOverrun, and the new keyCode overwrites the old one.
//     keyAck while keyPending==0 has no effect.
//   Latency: from a clean press to keyStrobe is <= (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 3 cycles.
// STRUCTURE
//   keypad_pkg: FSM state localparams (IDLE, DEB_PRESS, PRESSED, DEB_REL), NUM_COLS=4,
//     NUM_ROWS=4, scan-result encoding (NONE/SINGLE/MULTI).
//   Sub-module keypad_col_driver: divCnt, colIdx, colOut and the sample/scanDone pulses.
//     The debounce FSM and the handshake stay in keypad_scan.
// TESTING  (SCAN_DIV=8, DEBOUNCE_SCANS=3, keypad behavioural model)
//   Press row2/col1 and hold for 6 scans -> exactly one keyStrobe, keyCode=4'h9, keyDown=1,
//     keyPending=1; colOut cycles 1110,1101,1011,0111.
//   Press with 2-scan bounce (press/release/press), then stable -> strobe only after 3 clean
//     scans; a 2-scan press never strobes.
//   Press rows0+1 in col0 simultaneously -> MULTI, no strobe, FSM stays IDLE.
//   Hold 4'h5, add 4'hA, release 4'h5 while keeping 4'hA -> no second strobe until full release
//     plus a new 3-scan press.
//   Two accepted presses without keyAck -> keyOverrun=1, keyCode=second code. keyAck coinciding
//     with a strobe -> keyPending stays 1, keyOverrun=0.
//   Assert rstN low during DEB_PRESS -> all outputs at reset values immediately, colOut=1110;
//     no strobe after release of reset until a new full debounce.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 hex keypad scanner: matrix size,
// debounce FSM states and the per-scan result classification.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        PRESSED   = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_res_e;

endpackage

// File: rtl/keypad_col_driver.sv
// Column scan timebase: divides clk into column steps, drives exactly one
// active-low column and flags the sample cycle and the end-of-scan cycle.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 12000
) (
    input  logic       clk,
    input  logic       rstN,
    output logic [1:0] colIdx_o,
    output logic [3:0] colOut_o,
    output logic       sample_o,
    output logic       scanDone_o
);

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [1:0]       LAST_COL = 2'(NUM_COLS - 1);

    logic [DIV_W-1:0] divCnt_q, divCnt_d;
    logic [1:0]       colIdx_q, colIdx_d;
    logic [3:0]       colOut_q, colOut_d;
    logic             stepEn;

    // Next divider count, column index and column drive pattern
    always_comb begin
        stepEn   = (divCnt_q == DIV_LAST);
        divCnt_d = stepEn ? '0 : divCnt_q + 1'b1;
        colIdx_d = stepEn ? colIdx_q + 2'd1 : colIdx_q;
        colOut_d = ~(4'b0001 << colIdx_d);
    end

    // Timebase and column drive registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            divCnt_q <= '0;
            colIdx_q <= 2'd0;
            colOut_q <= 4'b1110;
        end else begin
            divCnt_q <= divCnt_d;
            colIdx_q <= colIdx_d;
            colOut_q <= colOut_d;
        end
    end

    // Rows are read on the last cycle of each column step; the col-3 read closes a scan
    assign sample_o   = stepEn;
    assign scanDone_o = stepEn && (colIdx_q == LAST_COL);
    assign colIdx_o   = colIdx_q;
    assign colOut_o   = colOut_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: synchronises the rows, classifies each full scan,
// debounces over whole scans and hands accepted key codes to a consumer
// through a pending/ack handshake with overrun detection.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [3:0] rowIn,
    output logic [3:0] colOut,
    output logic [3:0] keyCode,
    output logic       keyStrobe,
    output logic       keyDown,
    output logic       keyPending,
    input  logic       keyAck,
    output logic       keyOverrun
);

    localparam logic [2:0] DEB_TGT = 3'(DEBOUNCE_SCANS);

    // Number of low bits in one row read, saturated at 2 ("many")
    function automatic logic [1:0] low_count(input logic [3:0] lows);
        logic [2:0] n;
        n = 3'd0;
        for (int r = 0; r < NUM_ROWS; r++) n = n + {2'b00, lows[r]};
        return (n > 3'd1) ? 2'd2 : n[1:0];
    endfunction

    // Index of the lowest-numbered low row
    function automatic logic [1:0] first_low(input logic [3:0] lows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) if (lows[r]) idx = 2'(r);
        return idx;
    endfunction

    // Add two saturated counts, keeping the result saturated at 2
    function automatic logic [1:0] sat_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 3'd1) ? 2'd2 : s[1:0];
    endfunction

    // Saturating increment of the 3-bit stability counter
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v == 3'd7) ? 3'd7 : v + 3'd1;
    endfunction

    logic [1:0] colIdx;
    logic       sampleEn;
    logic       scanDone;

    keypad_col_driver #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_driver (
        .clk        (clk),
        .rstN       (rstN),
        .colIdx_o   (colIdx),
        .colOut_o   (colOut),
        .sample_o   (sampleEn),
        .scanDone_o (scanDone)
    );

    logic [3:0] rowMeta_q, rowSync_q;

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rowMeta_q <= 4'hF;
            rowSync_q <= 4'hF;
        end else begin
            rowMeta_q <= rowIn;
            rowSync_q <= rowMeta_q;
        end
    end

    logic [1:0] accCnt_q, accCnt_d;
    logic [3:0] accCode_q, accCode_d;
    logic [3:0] colLows;
    logic [1:0] colCnt, sumCnt;
    logic [3:0] mergedCode;
    scan_res_e  scanRes;

    // Fold the current column read into the scan accumulator and classify at end of scan
    always_comb begin
        colLows    = ~rowSync_q;
        colCnt     = low_count(colLows);
        sumCnt     = sat_add(accCnt_q, colCnt);
        mergedCode = (colCnt != 2'd0) ? {first_low(colLows), colIdx} : accCode_q;
        accCnt_d   = accCnt_q;
        accCode_d  = accCode_q;
        if (sampleEn) begin
            if (scanDone) begin
                accCnt_d  = 2'd0;
                accCode_d = 4'd0;
            end else begin
                accCnt_d  = sumCnt;
                accCode_d = mergedCode;
            end
        end
        if (sumCnt == 2'd0)      scanRes = RES_NONE;
        else if (sumCnt == 2'd1) scanRes = RES_SINGLE;
        else                     scanRes = RES_MULTI;
    end

    // Scan accumulator registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            accCnt_q  <= 2'd0;
            accCode_q <= 4'd0;
        end else begin
            accCnt_q  <= accCnt_d;
            accCode_q <= accCode_d;
        end
    end

    kp_state_e  state_q, state_d;
    logic [2:0] stableCnt_q, stableCnt_d;
    logic [3:0] cand_q, cand_d;
    logic [2:0] cntInc;
    logic       accept;
    logic [3:0] keyCode_q, keyCode_d;
    logic       keyStrobe_q, keyStrobe_d;
    logic       keyDown_q, keyDown_d;
    logic       keyPending_q, keyPending_d;
    logic       keyOverrun_q, keyOverrun_d;

    // Debounce FSM next state plus registered-output and handshake next values
    always_comb begin
        state_d     = state_q;
        stableCnt_d = stableCnt_q;
        cand_d      = cand_q;
        accept      = 1'b0;
        cntInc      = sat_inc(stableCnt_q);
        if (scanDone) begin
            case (state_q)
                IDLE: begin
                    if (scanRes == RES_SINGLE) begin
                        cand_d      = mergedCode;
                        stableCnt_d = 3'd1;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (scanRes == RES_SINGLE && mergedCode == cand_q) begin
                        stableCnt_d = cntInc;
                        if (cntInc >= DEB_TGT) begin
                            state_d = PRESSED;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    // No rollover: any key still down keeps us here
                    if (scanRes == RES_NONE) begin
                        stableCnt_d = 3'd1;
                        state_d     = (DEBOUNCE_SCANS == 1) ? IDLE : DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (scanRes == RES_NONE) begin
                        stableCnt_d = cntInc;
                        if (cntInc >= DEB_TGT) state_d = IDLE;
                    end else begin
                        // Release bounce of the held key: not a new press, so no strobe
                        state_d = PRESSED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        keyStrobe_d = accept;
        keyCode_d   = accept ? cand_d : keyCode_q;
        keyDown_d   = (state_d == PRESSED) || (state_d == DEB_REL);

        keyPending_d = keyPending_q;
        keyOverrun_d = keyOverrun_q;
        if (keyStrobe_q) begin
            // A new key always wins over a simultaneous ack
            keyPending_d = 1'b1;
            keyOverrun_d = keyAck ? 1'b0 : (keyOverrun_q | keyPending_q);
        end else if (keyAck) begin
            keyPending_d = 1'b0;
            keyOverrun_d = 1'b0;
        end
    end

    // FSM state, candidate code and output registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            stableCnt_q  <= 3'd0;
            cand_q       <= 4'd0;
            keyCode_q    <= 4'd0;
            keyStrobe_q  <= 1'b0;
            keyDown_q    <= 1'b0;
            keyPending_q <= 1'b0;
            keyOverrun_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            stableCnt_q  <= stableCnt_d;
            cand_q       <= cand_d;
            keyCode_q    <= keyCode_d;
            keyStrobe_q  <= keyStrobe_d;
            keyDown_q    <= keyDown_d;
            keyPending_q <= keyPending_d;
            keyOverrun_q <= keyOverrun_d;
        end
    end

    assign keyCode    = keyCode_q;
    assign keyStrobe  = keyStrobe_q;
    assign keyDown    = keyDown_q;
    assign keyPending = keyPending_q;
    assign keyOverrun = keyOverrun_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix model drives the rows from the
// pressed-key set, and a scan-level reference model predicts outputs.
module tb_keypad_scan;

    localparam int SD       = 8;
    localparam int DS       = 3;
    localparam int SCAN_CYC = 4 * SD;

    logic       clk = 1'b0;
    logic       rstN;
    logic [3:0] rowIn;
    logic [3:0] colOut;
    logic [3:0] keyCode;
    logic       keyStrobe;
    logic       keyDown;
    logic       keyPending;
    logic       keyAck;
    logic       keyOverrun;

    // Pressed keys, bit index = key code = row*4 + col
    logic [15:0] keys;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    bit         mHeld;
    int         mRun;
    int         mRel;
    logic [3:0] mCand;
    logic [3:0] mCode;
    logic       mStrobe;
    logic       mPend;
    logic       mOvr;

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .rowIn      (rowIn),
        .colOut     (colOut),
        .keyCode    (keyCode),
        .keyStrobe  (keyStrobe),
        .keyDown    (keyDown),
        .keyPending (keyPending),
        .keyAck     (keyAck),
        .keyOverrun (keyOverrun)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        rowIn = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!colOut[c])
                for (int r = 0; r < 4; r++)
                    if (keys[r*4 + c]) rowIn[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mHeld   = 1'b0;
        mRun    = 0;
        mRel    = 0;
        mCand   = 4'd0;
        mCode   = 4'd0;
        mStrobe = 1'b0;
        mPend   = 1'b0;
        mOvr    = 1'b0;
    endtask

    // One whole scan seen with key set k: count consecutive identical single-key
    // scans to accept, count consecutive empty scans to release
    task automatic model_scan(input logic [15:0] k);
        int         n;
        logic [3:0] code;
        n    = $countones(k);
        code = 4'd0;
        for (int b = 0; b < 16; b++) if (k[b]) code = 4'(b);
        mStrobe = 1'b0;
        if (!mHeld) begin
            if (n == 1 && mRun > 0 && code == mCand) mRun++;
            else if (n == 1 && mRun == 0) begin
                mRun  = 1;
                mCand = code;
            end else mRun = 0;
            if (mRun >= DS) begin
                mHeld   = 1'b1;
                mRun    = 0;
                mRel    = 0;
                mStrobe = 1'b1;
                mCode   = mCand;
            end
        end else begin
            if (n == 0) mRel++;
            else mRel = 0;
            if (mRel >= DS) begin
                mHeld = 1'b0;
                mRel  = 0;
            end
        end
    endtask

    task automatic check_reset_values();
        check("rst_colOut", colOut, 4'b1110);
        check("rst_keyCode", keyCode, 4'h0);
        check("rst_keyStrobe", {3'b0, keyStrobe}, 4'h0);
        check("rst_keyDown", {3'b0, keyDown}, 4'h0);
        check("rst_keyPending", {3'b0, keyPending}, 4'h0);
        check("rst_keyOverrun", {3'b0, keyOverrun}, 4'h0);
    endtask

    // Runs one full scan starting at a negedge right after a scan boundary;
    // ack is held for the first cycle, which is the strobe cycle of the previous scan
    task automatic do_scan(input logic [15:0] k, input bit ack);
        logic [3:0] expCol;
        keys   = k;
        keyAck = ack;
        if (mStrobe) begin
            mOvr  = ack ? 1'b0 : (mOvr | mPend);
            mPend = 1'b1;
        end else if (ack) begin
            mPend = 1'b0;
            mOvr  = 1'b0;
        end
        for (int i = 1; i <= SCAN_CYC; i++) begin
            @(posedge clk);
            @(negedge clk);
            keyAck = 1'b0;
            expCol = ~(4'b0001 << ((i / SD) % 4));
            check("colOut", colOut, expCol);
            if (i < SCAN_CYC) check("strobe_idle", {3'b0, keyStrobe}, 4'h0);
        end
        model_scan(k);
        check("keyStrobe", {3'b0, keyStrobe}, {3'b0, mStrobe});
        check("keyDown", {3'b0, keyDown}, {3'b0, mHeld});
        check("keyCode", keyCode, mCode);
        check("keyPending", {3'b0, keyPending}, {3'b0, mPend});
        check("keyOverrun", {3'b0, keyOverrun}, {3'b0, mOvr});
    endtask

    localparam logic [15:0] K9  = 16'h0200;
    localparam logic [15:0] K3  = 16'h0008;
    localparam logic [15:0] K5  = 16'h0020;
    localparam logic [15:0] KA  = 16'h0400;
    localparam logic [15:0] K7  = 16'h0080;
    localparam logic [15:0] KM  = 16'h0011;

    logic [15:0] cur;
    int          sel;

    initial begin
        rstN   = 1'b0;
        keys   = 16'h0;
        keyAck = 1'b0;
        model_reset();
        #12;
        check_reset_values();
        @(negedge clk);
        rstN = 1'b1;

        // Row2/col1 held for six scans: one strobe, code 9
        for (int s = 0; s < 6; s++) do_scan(K9, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);

        // Bouncy press of key 3; ack on the first scan clears the pending 9
        do_scan(K3, 1'b1);
        do_scan(K3, 1'b0);
        do_scan(16'h0, 1'b0);
        do_scan(K3, 1'b0);
        do_scan(K3, 1'b0);
        do_scan(16'h0, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(K3, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);

        // Two keys in the same column: never accepted
        for (int s = 0; s < 4; s++) do_scan(KM, 1'b0);
        do_scan(16'h0, 1'b0);

        // Hold 5 (accepted while 3 still pending -> overrun), roll onto A without a new strobe
        for (int s = 0; s < 3; s++) do_scan(K5, 1'b0);
        for (int s = 0; s < 2; s++) do_scan(K5 | KA, 1'b0);
        for (int s = 0; s < 4; s++) do_scan(KA, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(KA, 1'b0);
        // Ack in the strobe cycle: pending stays, overrun clears
        do_scan(KA, 1'b1);
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);

        // Randomised key activity with occasional acks
        cur = 16'h0;
        for (int s = 0; s < 48; s++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4) cur = cur;
            else if (sel < 6) cur = 16'h0;
            else if (sel < 9) cur = 16'h0001 << $urandom_range(0, 15);
            else cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            do_scan(cur, ($urandom_range(0, 3) == 0));
        end

        // Leave pending set with a nonzero code, then reset in the middle of DEB_PRESS
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(K7, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b0);
        for (int s = 0; s < 2; s++) do_scan(KA, 1'b0);
        repeat (10) @(negedge clk);
        #1 rstN = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        // Key still held: a full fresh debounce is required
        for (int s = 0; s < 4; s++) do_scan(KA, 1'b0);
        for (int s = 0; s < 3; s++) do_scan(16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
